// File: rtl/commit_write_scheduler_pkg.sv
// ============================================================================
// Module      : commit_write_scheduler_pkg
// Description : Shared types for the commit write scheduler slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package commit_write_scheduler_pkg;

  typedef logic        bool;
  typedef logic [4:0]  REG_ADDR;
  typedef logic [31:0] REG_WIDTH;

  typedef struct packed {
    bool      write_reg_need;
    REG_ADDR  write_reg_addr;
    REG_WIDTH result;
  } CMT_REQUIRE;

  typedef struct packed {
    REG_ADDR  addr;
    REG_WIDTH data;
  } PENDING_WR;

  localparam int CMT_BUF_DEPTH_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/pending_wr_lookup.sv
// ============================================================================
// Module      : pending_wr_lookup
// Description : Combinational youngest-match search over the pending writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pending_wr_lookup
  import commit_write_scheduler_pkg::*;
#(
  parameter  int DEPTH = CMT_BUF_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  PENDING_WR [DEPTH-1:0] entries,
  input  logic [PTR_W-1:0]      rd_ptr,
  input  logic [PTR_W:0]        count,
  input  REG_ADDR               addr,
  output bool                   hit,
  output REG_WIDTH              data
);

  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest so the last match seen is the newest writer.
  always_comb begin
    hit   = 1'b0;
    data  = '0;
    w_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = rd_ptr + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && (entries[w_idx].addr == addr) && (addr != '0)) begin
        hit  = 1'b1;
        data = entries[w_idx].data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/commit_write_scheduler.sv
// ============================================================================
// Module      : commit_write_scheduler
// Description : Buffers dual-issue commit writes and drains one per cycle to a
//               single-port regfile, with forwarding lookups for decode.
//               Optional macro COMMIT_COALESCE_EN merges same-address pairs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_write_scheduler
  import commit_write_scheduler_pkg::*;
#(
  parameter  int DEPTH = CMT_BUF_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmt_valid,
  input  CMT_REQUIRE [1:0]     cmt_require,
  output logic                 cmt_ready,
  output logic                 regfile_write_ena,
  output REG_ADDR              regfile_write_addr,
  output REG_WIDTH             regfile_write_data,
  input  REG_ADDR [1:0]        fwd_addr,
  output logic [1:0]           fwd_hit,
  output REG_WIDTH [1:0]       fwd_data,
  output logic [PTR_W:0]       pending_cnt
);

  localparam logic [PTR_W:0] c_ready_max = (PTR_W+1)'(DEPTH - 2);

  PENDING_WR [DEPTH-1:0] r_buf;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;

  logic           w_accept;
  logic           w_v0;
  logic           w_v1;
  logic           w_v0_eff;
  logic           w_push_a;
  logic           w_push_b;
  logic           w_pop;
  logic [PTR_W:0] w_push_cnt;
  PENDING_WR      w_first;
  PENDING_WR      w_second;

  assign cmt_ready = (r_count <= c_ready_max);
  assign w_accept  = cmt_valid && cmt_ready;

  // Writes to $0 are architecturally dead and never occupy a slot.
  assign w_v0 = cmt_require[0].write_reg_need && (cmt_require[0].write_reg_addr != '0);
  assign w_v1 = cmt_require[1].write_reg_need && (cmt_require[1].write_reg_addr != '0);

`ifdef COMMIT_COALESCE_EN
  assign w_v0_eff = w_v0 && !(w_v1 &&
                    (cmt_require[0].write_reg_addr == cmt_require[1].write_reg_addr));
`else
  assign w_v0_eff = w_v0;
`endif

  assign w_push_a   = w_accept && (w_v0_eff || w_v1);
  assign w_push_b   = w_accept && w_v0_eff && w_v1;
  assign w_push_cnt = (PTR_W+1)'(w_push_a) + (PTR_W+1)'(w_push_b);
  assign w_pop      = (r_count != '0);

  assign w_first  = w_v0_eff ? PENDING_WR'{cmt_require[0].write_reg_addr, cmt_require[0].result}
                             : PENDING_WR'{cmt_require[1].write_reg_addr, cmt_require[1].result};
  assign w_second = PENDING_WR'{cmt_require[1].write_reg_addr, cmt_require[1].result};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_push_cnt[PTR_W-1:0];
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
      r_count  <= r_count + w_push_cnt - (PTR_W+1)'(w_pop);
    end
  end

  // Payload storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_push_a) r_buf[r_wr_ptr] <= w_first;
    if (w_push_b) r_buf[r_wr_ptr + PTR_W'(1)] <= w_second;
  end

  assign regfile_write_ena  = w_pop;
  assign regfile_write_addr = w_pop ? r_buf[r_rd_ptr].addr : '0;
  assign regfile_write_data = w_pop ? r_buf[r_rd_ptr].data : '0;
  assign pending_cnt        = r_count;

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    pending_wr_lookup #(.DEPTH(DEPTH)) u_lookup (
      .entries (r_buf),
      .rd_ptr  (r_rd_ptr),
      .count   (r_count),
      .addr    (fwd_addr[g]),
      .hit     (fwd_hit[g]),
      .data    (fwd_data[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_commit_write_scheduler.sv
// ============================================================================
// Module      : tb_commit_write_scheduler
// Description : Directed vector table plus back-pressure and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_write_scheduler;
  import commit_write_scheduler_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmt_valid;
  CMT_REQUIRE [1:0] cmt_require;
  logic             cmt_ready;
  logic             regfile_write_ena;
  REG_ADDR          regfile_write_addr;
  REG_WIDTH         regfile_write_data;
  REG_ADDR [1:0]    fwd_addr;
  logic [1:0]       fwd_hit;
  REG_WIDTH [1:0]   fwd_data;
  logic [2:0]       pending_cnt;

  int n_pass  = 0;
  int n_total = 0;

  commit_write_scheduler #(.DEPTH(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .cmt_valid          (cmt_valid),
    .cmt_require        (cmt_require),
    .cmt_ready          (cmt_ready),
    .regfile_write_ena  (regfile_write_ena),
    .regfile_write_addr (regfile_write_addr),
    .regfile_write_data (regfile_write_data),
    .fwd_addr           (fwd_addr),
    .fwd_hit            (fwd_hit),
    .fwd_data           (fwd_data),
    .pending_cnt        (pending_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        n0; logic [4:0] a0; logic [31:0] d0;
    logic        n1; logic [4:0] a1; logic [31:0] d1;
    logic [4:0]  f0; logic [4:0] f1;
    logic        rdy; logic ena; logic [4:0] wa; logic [31:0] wd; logic [2:0] cnt;
    logic        h0; logic [31:0] fd0; logic h1; logic [31:0] fd1;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic n0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic n1, input logic [4:0] a1, input logic [31:0] d1);
    cmt_valid = v;
    cmt_require[0].write_reg_need = n0;
    cmt_require[0].write_reg_addr = a0;
    cmt_require[0].result         = d0;
    cmt_require[1].write_reg_need = n1;
    cmt_require[1].write_reg_addr = a1;
    cmt_require[1].result         = d1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  exp_a[$];
    logic [31:0] exp_d[$];
    int          mcount;
    int          k;
    logic        exp_rdy;
    logic        saw_stall;
    logic        was_pop;
    logic [4:0]  pa;

    // Rows run back to back: outputs are sampled before the edge that applies the row.
    vecs[0]  = '{0, 0,0,0,      0,0,0,      0,0,  1,0,0,0,0,     0,0,0,0};
    vecs[1]  = '{1, 1,5,'h11,   0,0,0,      5,0,  1,0,0,0,0,     0,0,0,0};
    vecs[2]  = '{0, 0,0,0,      0,0,0,      5,0,  1,1,5,'h11,1,  1,'h11,0,0};
    vecs[3]  = '{1, 1,3,'hA,    1,4,'hB,    5,0,  1,0,0,0,0,     0,0,0,0};
    vecs[4]  = '{0, 0,0,0,      0,0,0,      3,4,  1,1,3,'hA,2,   1,'hA,1,'hB};
    vecs[5]  = '{0, 0,0,0,      0,0,0,      3,4,  1,1,4,'hB,1,   0,0,1,'hB};
    vecs[6]  = '{1, 1,7,1,      1,7,2,      7,0,  1,0,0,0,0,     0,0,0,0};
`ifdef COMMIT_COALESCE_EN
    vecs[7]  = '{0, 0,0,0,      0,0,0,      7,0,  1,1,7,2,1,     1,2,0,0};
    vecs[8]  = '{0, 0,0,0,      0,0,0,      7,0,  1,0,0,0,0,     0,0,0,0};
`else
    vecs[7]  = '{0, 0,0,0,      0,0,0,      7,0,  1,1,7,1,2,     1,2,0,0};
    vecs[8]  = '{0, 0,0,0,      0,0,0,      7,0,  1,1,7,2,1,     1,2,0,0};
`endif
    vecs[9]  = '{0, 0,0,0,      0,0,0,      7,0,  1,0,0,0,0,     0,0,0,0};
    vecs[10] = '{1, 1,0,'hFFFF, 1,0,'hFFFF, 0,0,  1,0,0,0,0,     0,0,0,0};
    vecs[11] = '{0, 0,0,0,      0,0,0,      0,0,  1,0,0,0,0,     0,0,0,0};
    vecs[12] = '{1, 0,9,'h99,   1,10,'hAA,  9,0,  1,0,0,0,0,     0,0,0,0};
    vecs[13] = '{0, 0,0,0,      0,0,0,      9,10, 1,1,10,'hAA,1, 0,0,1,'hAA};
    vecs[14] = '{0, 0,0,0,      0,0,0,      0,0,  1,0,0,0,0,     0,0,0,0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    fwd_addr[0] = '0;
    fwd_addr[1] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].n0, vecs[i].a0, vecs[i].d0, vecs[i].n1, vecs[i].a1, vecs[i].d1);
      fwd_addr[0] = vecs[i].f0;
      fwd_addr[1] = vecs[i].f1;
      #1;
      check($sformatf("row%0d ready", i), 32'(cmt_ready),          32'(vecs[i].rdy));
      check($sformatf("row%0d ena", i),   32'(regfile_write_ena),  32'(vecs[i].ena));
      check($sformatf("row%0d waddr", i), 32'(regfile_write_addr), 32'(vecs[i].wa));
      check($sformatf("row%0d wdata", i), regfile_write_data,      vecs[i].wd);
      check($sformatf("row%0d cnt", i),   32'(pending_cnt),        32'(vecs[i].cnt));
      check($sformatf("row%0d hit0", i),  32'(fwd_hit[0]),         32'(vecs[i].h0));
      check($sformatf("row%0d fdat0", i), fwd_data[0],             vecs[i].fd0);
      check($sformatf("row%0d hit1", i),  32'(fwd_hit[1]),         32'(vecs[i].h1));
      check($sformatf("row%0d fdat1", i), fwd_data[1],             vecs[i].fd1);
    end

    // Back-pressure: offer a fresh pair every cycle; held pairs must not be lost.
    mcount    = 0;
    k         = 0;
    saw_stall = 1'b0;
    fwd_addr[0] = '0;
    fwd_addr[1] = '0;
    for (int cyc = 0; cyc < 200 && !(k == 8 && mcount == 0); cyc++) begin
      @(negedge clk);
      pa = 5'((2 * k) % 30 + 1);
      if (k < 8) drive(1, 1, pa, 32'h100 + 32'(2 * k), 1, pa + 5'd1, 32'h101 + 32'(2 * k));
      else       drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      exp_rdy = ((4 - mcount) >= 2);
      if (!exp_rdy) saw_stall = 1'b1;
      check("bp ready", 32'(cmt_ready), 32'(exp_rdy));
      check("bp cnt", 32'(pending_cnt), 32'(mcount));
      was_pop = (mcount != 0);
      check("bp ena", 32'(regfile_write_ena), 32'(was_pop));
      if (was_pop) begin
        if (exp_a.size() == 0) begin
          check("bp queue", 32'(exp_a.size()), 32'd1);
        end else begin
          check("bp order addr", 32'(regfile_write_addr), 32'(exp_a.pop_front()));
          check("bp order data", regfile_write_data, exp_d.pop_front());
        end
      end
      if (cmt_valid && exp_rdy) begin
        exp_a.push_back(pa);
        exp_d.push_back(32'h100 + 32'(2 * k));
        exp_a.push_back(pa + 5'd1);
        exp_d.push_back(32'h101 + 32'(2 * k));
        k++;
        mcount += 2;
      end
      if (was_pop) mcount--;
    end
    check("bp all drained", 32'((k == 8) && (mcount == 0)), 32'd1);
    check("bp stall seen", 32'(saw_stall), 32'd1);

    // Reset with three writes pending.
    @(negedge clk);
    drive(1, 1, 11, 32'h511, 1, 12, 32'h512);
    #1;
    check("rs cnt0", 32'(pending_cnt), 32'd0);
    @(negedge clk);
    drive(1, 1, 13, 32'h513, 1, 14, 32'h514);
    #1;
    check("rs cnt2", 32'(pending_cnt), 32'd2);
    check("rs waddr11", 32'(regfile_write_addr), 32'd11);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    fwd_addr[0] = 5'd13;
    #1;
    check("rs cnt3", 32'(pending_cnt), 32'd3);
    check("rs ready full", 32'(cmt_ready), 32'd0);
    check("rs waddr12", 32'(regfile_write_addr), 32'd12);
    check("rs hit before", 32'(fwd_hit[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rs ena after", 32'(regfile_write_ena), 32'd0);
    check("rs cnt after", 32'(pending_cnt), 32'd0);
    check("rs ready after", 32'(cmt_ready), 32'd1);
    check("rs hit after", 32'(fwd_hit[0]), 32'd0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      #1;
      check($sformatf("rs quiet%0d", j), 32'(regfile_write_ena), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
